// File: rtl/pid_sequencer.sv
// pid_sequencer
//   Initiator for the pid start_calc/done handshake. A sample tick latches the
//   setpoint and measured position, the sign-magnitude error is formed, one PID
//   calculation is launched, and the returned PID_out is mapped onto a biased,
//   clamped, unsigned actuator command.
//
//   Optional feature: define PID_SEQ_SLEW_EN to limit each command update to at
//   most SLEW_MAX counts. Undefined, the command takes the clamped value directly.
//
//   Ports
//     clk, rst            rising-edge clock, synchronous active-high reset
//     en, tick            tick acceptance enable and one-cycle sample strobe
//     setpoint, measured  sign-magnitude operands (bit 31 = sign)
//     start_calc, error   launch pulse and sign-magnitude error to pid
//     done, PID_out       pid completion level and sign-magnitude result
//     cmd, cmd_valid      actuator command and its update pulse
//     busy                high whenever not idle
//     overrun, timeout    dropped-tick pulse and done-wait expiry pulse
module pid_sequencer #(
    parameter int CMD_W          = 16,
    parameter int CMD_BIAS       = 1000,
    parameter int OUT_SHIFT      = 5,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int SLEW_MAX       = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             tick,
    input  logic [31:0]      setpoint,
    input  logic [31:0]      measured,
    output logic             start_calc,
    output logic [31:0]      error,
    input  logic             done,
    input  logic [31:0]      PID_out,
    output logic [CMD_W-1:0] cmd,
    output logic             cmd_valid,
    output logic             busy,
    output logic             overrun,
    output logic             timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W:0]     TO_VAL    = TIMEOUT_CYCLES[CNT_W:0];
    localparam logic signed [33:0] BIAS_S    = 34'(CMD_BIAS);
    localparam logic signed [33:0] CMD_MAX_S = (34'sd1 <<< CMD_W) - 34'sd1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CALC  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        APPLY = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      sp_q, sp_d;
    logic [31:0]      ms_q, ms_d;
    logic [31:0]      err_q, err_d;
    logic [31:0]      pid_q, pid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;

    // datapath results
    logic [31:0]        err_calc;
    logic [CMD_W-1:0]   cmd_next;
    logic [CNT_W:0]     cnt_inc;

    // ------------------------------------------------------------------
    // Sign-magnitude subtraction setpoint - measured, saturating, never -0
    // ------------------------------------------------------------------
    logic [31:0] sp_mag, ms_mag, sum_mag, res_mag;
    logic        res_sgn;

    always_comb begin
        sp_mag  = {1'b0, sp_q[30:0]};
        ms_mag  = {1'b0, ms_q[30:0]};
        sum_mag = sp_mag + ms_mag;
        res_mag = '0;
        res_sgn = 1'b0;
        if (sp_q[31] == ms_q[31]) begin
            // same sign: the larger magnitude decides the result sign
            if (sp_mag >= ms_mag) begin
                res_mag = sp_mag - ms_mag;
                res_sgn = sp_q[31];
            end else begin
                res_mag = ms_mag - sp_mag;
                res_sgn = ~sp_q[31];
            end
        end else begin
            // opposite signs: magnitudes add, sign follows the setpoint
            res_mag = sum_mag[31] ? 32'h7FFF_FFFF : sum_mag;
            res_sgn = sp_q[31];
        end
        if (res_mag == '0) res_sgn = 1'b0;
        err_calc = {res_sgn, res_mag[30:0]};
    end

    // ------------------------------------------------------------------
    // Command mapping: bias +/- scaled magnitude, clamp, optional slew
    // ------------------------------------------------------------------
    logic signed [33:0] mag_s, v_s, tgt_s;

    always_comb begin
        mag_s = $signed({3'b000, pid_q[30:0]} >> OUT_SHIFT);
        v_s   = pid_q[31] ? (BIAS_S - mag_s) : (BIAS_S + mag_s);
        if (v_s < 34'sd0)          tgt_s = 34'sd0;
        else if (v_s > CMD_MAX_S)  tgt_s = CMD_MAX_S;
        else                       tgt_s = v_s;
    end

`ifdef PID_SEQ_SLEW_EN
    localparam logic signed [33:0] SLEW_S = 34'(SLEW_MAX);
    logic signed [33:0] cur_s, diff_s, step_s;

    always_comb begin
        cur_s  = $signed({{(34-CMD_W){1'b0}}, cmd_q});
        diff_s = tgt_s - cur_s;
        if (diff_s > SLEW_S)        step_s = cur_s + SLEW_S;
        else if (diff_s < -SLEW_S)  step_s = cur_s - SLEW_S;
        else                        step_s = tgt_s;
        cmd_next = step_s[CMD_W-1:0];
    end
`else
    logic unused_slew;
    assign unused_slew = ^SLEW_MAX;

    always_comb begin
        cmd_next = tgt_s[CMD_W-1:0];
    end
`endif

    assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Next-state / register-update logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        ms_d        = ms_q;
        err_d       = err_q;
        pid_d       = pid_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        timeout_d   = 1'b0;
        // any tick outside IDLE is lost, including one coincident with done
        overrun_d   = tick && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (tick && en) begin
                    sp_d    = setpoint;
                    ms_d    = measured;
                    state_d = CALC;
                end
            end
            CALC: begin
                err_d   = err_calc;
                state_d = START;
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (done) begin
                    pid_d   = PID_out;
                    state_d = APPLY;
                end else begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                    if (cnt_inc == TO_VAL) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            APPLY: begin
                cmd_d       = cmd_next;
                cmd_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sp_q        <= '0;
            ms_q        <= '0;
            err_q       <= '0;
            pid_q       <= '0;
            cnt_q       <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            ms_q        <= ms_d;
            err_q       <= err_d;
            pid_q       <= pid_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
        end
    end

    assign start_calc = (state_q == START);
    assign busy       = (state_q != IDLE);
    assign error      = err_q;
    assign cmd        = cmd_q;
    assign cmd_valid  = cmd_valid_q;
    assign overrun    = overrun_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_pid_sequencer.sv
// Testbench for pid_sequencer: randomized transactions with a scoreboard.
// Stimulus pushes the expected error/command; a negedge monitor pops and
// compares whenever start_calc or cmd_valid is presented.
module tb_pid_sequencer;

    localparam int CMD_W          = 16;
    localparam int CMD_BIAS       = 1000;
    localparam int OUT_SHIFT      = 5;
    localparam int TIMEOUT_CYCLES = 255;
    localparam int SLEW_MAX       = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b1;
    logic             tick = 1'b0;
    logic [31:0]      setpoint = '0;
    logic [31:0]      measured = '0;
    logic             start_calc;
    logic [31:0]      error;
    logic             done = 1'b0;
    logic [31:0]      PID_out = '0;
    logic [CMD_W-1:0] cmd;
    logic             cmd_valid;
    logic             busy;
    logic             overrun;
    logic             timeout;

    pid_sequencer #(
        .CMD_W(CMD_W), .CMD_BIAS(CMD_BIAS), .OUT_SHIFT(OUT_SHIFT),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .SLEW_MAX(SLEW_MAX)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .tick(tick),
        .setpoint(setpoint), .measured(measured),
        .start_calc(start_calc), .error(error),
        .done(done), .PID_out(PID_out),
        .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy),
        .overrun(overrun), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int sc_cyc = 0;
    int tmo_exp = 0, tmo_seen = 0;
    int ovr_exp = 0, ovr_seen = 0;
    longint model_cmd = 0;

    logic [31:0]      exp_err[$];
    logic [CMD_W-1:0] exp_cmd[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_err(input logic [31:0] sp, input logic [31:0] ms);
        longint a, b, d, mag;
        logic   s;
        a = sp[31] ? -longint'(sp[30:0]) : longint'(sp[30:0]);
        b = ms[31] ? -longint'(ms[30:0]) : longint'(ms[30:0]);
        d = a - b;
        s = (d < 0);
        mag = s ? -d : d;
        if (mag > 64'h7FFF_FFFF) mag = 64'h7FFF_FFFF;
        return {s, mag[30:0]};
    endfunction

    function automatic longint ref_target(input logic [31:0] p);
        longint m, v;
        m = longint'(p[30:0]) >>> OUT_SHIFT;
        v = p[31] ? CMD_BIAS - m : CMD_BIAS + m;
        if (v < 0) v = 0;
        if (v > (64'sd1 <<< CMD_W) - 1) v = (64'sd1 <<< CMD_W) - 1;
        return v;
    endfunction

    // advances the model command toward the target, returns the new value
    function automatic longint ref_update(input longint tgt);
        longint r;
        r = tgt;
`ifdef PID_SEQ_SLEW_EN
        if (tgt > model_cmd + SLEW_MAX) r = model_cmd + SLEW_MAX;
        if (tgt < model_cmd - SLEW_MAX) r = model_cmd - SLEW_MAX;
`endif
        model_cmd = r;
        return r;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (start_calc) begin
                sc_cyc = cyc;
                if (exp_err.size() == 0) check("unexpected_start_calc", 1, 0);
                else check("error", error, exp_err.pop_front());
            end
            if (cmd_valid) begin
                if (exp_cmd.size() == 0) check("unexpected_cmd_valid", 1, 0);
                else check("cmd", cmd, exp_cmd.pop_front());
            end
            if (timeout) begin
                tmo_seen++;
                check("timeout_latency", cyc - sc_cyc, TIMEOUT_CYCLES + 1);
                check("timeout_cmd_unchanged", cmd, model_cmd);
            end
            if (overrun) ovr_seen++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick_in(input logic [31:0] sp, input logic [31:0] ms);
        @(posedge clk); #1;
        setpoint = sp; measured = ms; tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0; setpoint = $urandom; measured = $urandom;
    endtask

    task automatic launch(input logic [31:0] sp, input logic [31:0] ms, input bit drop_en);
        exp_err.push_back(ref_err(sp, ms));
        tick_in(sp, ms);
        if (drop_en) en = 1'b0;
        @(negedge clk);
        check("calc_busy", busy, 1);
        check("calc_no_start", start_calc, 0);
        @(negedge clk);
        check("start_at_T2", start_calc, 1);
    endtask

    // ovr: 0 none, 1 tick together with done, 2 tick in first WAIT cycle
    task automatic run_txn(input logic [31:0] sp, input logic [31:0] ms,
                           input logic [31:0] pid, input int dly,
                           input int ovr, input bit drop_en);
        launch(sp, ms, drop_en);
        for (int i = 0; i < dly; i++) begin
            @(posedge clk); #1;
            tick = (ovr == 2 && i == 0);
            if (tick) ovr_exp++;
        end
        @(posedge clk); #1;
        tick = (ovr == 1);
        if (tick) ovr_exp++;
        done = 1'b1; PID_out = pid;
        exp_cmd.push_back(CMD_W'(ref_update(ref_target(pid))));
        @(posedge clk); #1;
        done = 1'b0; tick = 1'b0; PID_out = $urandom;
        @(negedge clk);
        check("apply_no_valid", cmd_valid, 0);
        check("apply_busy", busy, 1);
        @(negedge clk);
        check("cmd_valid_at_D1", cmd_valid, 1);
        check("busy_low_after_D1", busy, 0);
        en = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd"}, cmd, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_flags"}, {start_calc, cmd_valid, busy, overrun, timeout}, 0);
    endtask

    function automatic logic [31:0] rand_sm();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 2))
            0: r[30:0] = 31'($urandom_range(0, 5000));
            1: r[30:0] = 31'($urandom_range(0, 1 << 20));
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1 rst = 1'b0;

        // directed cases
        run_txn(32'd1000, 32'd400, 32'd640, 4, 0, 0);                   // err 0x258, cmd 1020
        run_txn({1'b1, 31'd900000}, 32'd5000, 32'd0, 2, 0, 0);         // err {1,905000}
        run_txn(32'd7, 32'd7, {1'b1, 31'd3200}, 1, 0, 0);              // err +0
        run_txn(32'h7FFF_FFFF, {1'b1, 31'd5}, {1'b1, 31'h4000_0000}, 3, 0, 0); // sat, clamp 0
        run_txn({1'b1, 31'd5}, {1'b1, 31'd9}, {1'b0, 31'h4000_0000}, 3, 0, 0); // clamp max
        run_txn({1'b1, 31'd0}, 32'd0, 32'd64, 2, 2, 0);                // -0 minus +0, overrun in WAIT
        run_txn(32'd12, 32'd30, {1'b1, 31'd31}, 3, 1, 1);              // tick with done, en drop

        // timeout: done withheld, late done ignored
        launch(32'd50, 32'd10, 0);
        tmo_exp++;
        repeat (300) @(posedge clk);
        @(negedge clk);
        check("timeout_busy_low", busy, 0);
        @(posedge clk); #1 done = 1'b1; PID_out = 32'd9999;
        @(posedge clk); #1 done = 1'b0;
        repeat (3) @(negedge clk);

        // tick with en low in IDLE: ignored silently
        en = 1'b0;
        tick_in(32'd100, 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("en_low_idle", busy, 0);
        end
        en = 1'b1;

        // done while idle: ignored
        @(posedge clk); #1 done = 1'b1; PID_out = 32'd320;
        @(posedge clk); #1 done = 1'b0;
        @(negedge clk);
        check("done_idle_ignored", busy, 0);

        // reset mid-WAIT
        launch(32'd5, 32'd1, 0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals("mid_reset");
        model_cmd = 0;
        run_txn(32'd1000, 32'd400, 32'd640, 4, 0, 0);  // 1020, or 64 when slew-limited

        // random transactions
        for (int k = 0; k < 40; k++) begin
            logic [31:0] p;
            p = rand_sm();
            if ($urandom_range(0, 3) == 0) p[30:0] = 31'($urandom_range(0, 70000));
            run_txn(rand_sm(), rand_sm(), p, $urandom_range(1, 8),
                    $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
        end

        repeat (4) @(negedge clk);
        check("err_queue_drained", exp_err.size(), 0);
        check("cmd_queue_drained", exp_cmd.size(), 0);
        check("timeout_count", tmo_seen, tmo_exp);
        check("overrun_count", ovr_seen, ovr_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pid_sequencer.md
# pid_sequencer

Initiator side of the `pid` start_calc/done handshake. On each sample tick it latches a setpoint and a measured position, forms the sign-magnitude error, and launches one PID calculation. It waits for `done` (or a timeout), then maps the sign-magnitude `PID_out` onto a biased, clamped, unsigned actuator command. It sits between the sensor/attitude path and the motor/PWM drivers in the flight-controller loop.

## Interface
- `CMD_W`, 16: actuator command width (unsigned).
- `CMD_BIAS`, 1000: command value for zero PID output; must be < 2^CMD_W.
- `OUT_SHIFT`, 5: arithmetic right shift applied to the `PID_out` magnitude before biasing.
- `TIMEOUT_CYCLES`, 255: maximum cycles to wait for `done` after `start_calc`.
- `SLEW_MAX`, 64: maximum per-update command change (used only with `PID_SEQ_SLEW_EN`).

- `clk` in 1: clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: enables acceptance of new ticks.
- `tick` in 1: sample strobe, one cycle wide.
- `setpoint` in 32: sign-magnitude target; bit 31 is the sign.
- `measured` in 32: sign-magnitude current position.
- `start_calc` out 1: one-cycle pulse to `pid`.
- `error` out 32: sign-magnitude error to `pid`.
- `done` in 1: `pid` completion; sampled level, high for at least one cycle.
- `PID_out` in 32: sign-magnitude result, valid while `done` is high.
- `cmd` out CMD_W: actuator command.
- `cmd_valid` out 1: one-cycle pulse when `cmd` updates.
- `busy` out 1: high in any state other than IDLE.
- `overrun` out 1: one-cycle pulse when a tick is dropped while busy.
- `timeout` out 1: one-cycle pulse when the `done` wait expires.

## Operation
- States: IDLE, CALC, START, WAIT, APPLY.
- **IDLE:**
  - `tick` with `en` high latches `setpoint`/`measured` and moves to CALC.
  - `tick` with `en` low is ignored and raises no flag.
- **CALC:**
  - Registers `error` = setpoint − measured in sign-magnitude: equal signs subtract magnitudes; differing signs add magnitudes.
  - Result magnitude saturates at 2^31−1.
  - A zero result is always encoded +0 (0x00000000), never −0.
- **START:**
  - `start_calc` is high for exactly this cycle.
  - The timeout counter clears.
  - `error` holds stable from here until the state returns to IDLE.
- **WAIT:**
  - `done` high latches `PID_out` and moves to APPLY.
  - Otherwise the counter increments; when it reaches TIMEOUT_CYCLES, pulse `timeout` and return to IDLE with `cmd` unchanged.
- **APPLY:**
  - v = CMD_BIAS ± (PID_out[30:0] >> OUT_SHIFT); the sign is taken from PID_out[31].
  - v is computed at 34 bits signed and then clamped to [0, 2^CMD_W−1].
  - Register `cmd` = v, pulse `cmd_valid`, return to IDLE.
- `tick` in any non-IDLE state is dropped and pulses `overrun`.
- `en` falling mid-transaction does not abort; the current transaction completes.
- `done` seen outside WAIT is ignored.

## Timing
- Tick accepted at edge T:
  - CALC during T+1.
  - `error` valid and `start_calc` high during T+2.
  - WAIT from T+3.
- `done` sampled high at edge D gives `cmd`/`cmd_valid` updated after D+1; `busy` falls after D+1.
- The earliest next accepted tick is edge D+2.
- Timeout: `timeout` pulses on the cycle after the TIMEOUT_CYCLES-th WAIT cycle without `done`.
- **Reset values** (`rst` high at any edge, including mid-transaction):
  - state IDLE.
  - `cmd` = 0 (motors off, not CMD_BIAS).
  - `error` = 0; `start_calc`, `cmd_valid`, `busy`, `overrun`, `timeout` = 0.
  - Latched operands and counter cleared.
- Simultaneous `tick` and `done` in WAIT: `done` is processed and the tick raises `overrun`.

## Configuration
- `PID_SEQ_SLEW_EN` defined:
  - In APPLY, `cmd` moves toward the clamped v by at most SLEW_MAX per update.
  - The first update after reset starts from 0.
  - `cmd_valid` pulses even if the step is limited.
- `PID_SEQ_SLEW_EN` undefined: `cmd` takes the clamped v directly, and `SLEW_MAX` is unused.

## Test plan
- **Nominal:** setpoint +1000, measured +400 gives `error` 0x00000258 with `start_calc` at T+2. Return `PID_out` +640 after 4 cycles; expect `cmd` = 1020 with `cmd_valid` at D+1.
- **Mixed signs:** setpoint {1, 900000}, measured +5000 gives `error` {1, 905000}. Setpoint = measured = +7 gives `error` 0x00000000, not 0x80000000.
- **Clamp:** `PID_out` {1, 2^30} gives `cmd` 0. `PID_out` {0, 2^30} gives `cmd` 65535 (slew macro undefined).
- **Timeout:** withhold `done` for 300 cycles; expect a `timeout` pulse after 255 WAIT cycles, `cmd` unchanged, and `busy` low. A later `done` is ignored.
- **Overrun/enable:** a tick during WAIT pulses `overrun`, and the transaction still completes with one `cmd_valid`. A tick with `en` = 0 in IDLE gives no `start_calc` and no flag.
- **Reset mid-WAIT:** assert `rst` one cycle; expect all outputs at reset values next cycle, and a new tick accepted normally. With `PID_SEQ_SLEW_EN` and SLEW_MAX 64, a first target of 1020 yields `cmd` 64.
